// File: rtl/cpu5_icache_pkg.sv
// Shared types and address-split width helpers for the CPU5 instruction cache.
`ifndef CPU5_XLEN
`define CPU5_XLEN 32
`endif

package cpu5_icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic int unsigned off_w(input int unsigned xlen);
    return $clog2(xlen / 8);
  endfunction

  function automatic int unsigned wb_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned ib_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned xlen,
                                        input int unsigned lines, input int unsigned words);
    return addr_w - off_w(xlen) - wb_w(words) - ib_w(lines);
  endfunction

endpackage

// File: rtl/cpu5_icache_array.sv
// Direct-mapped line storage: data words, tags and valid bits with a
// combinational read port, a word write port, a tag/valid set port and a global clear.
module cpu5_icache_array
  import cpu5_icache_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned LINES = 16,
  parameter  int unsigned WORDS = 4,
  parameter  int unsigned TAG_W = 24,
  localparam int unsigned IB    = ib_w(LINES),
  localparam int unsigned WB    = wb_w(WORDS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IB-1:0]    rd_idx,
  input  logic [WB-1:0]    rd_wsel,
  output logic             rd_valid_c,
  output logic [TAG_W-1:0] rd_tag_c,
  output logic [XLEN-1:0]  rd_word_c,
  input  logic             wr_en,
  input  logic [IB-1:0]    wr_idx,
  input  logic [WB-1:0]    wr_wsel,
  input  logic [XLEN-1:0]  wr_data,
  input  logic             set_en,
  input  logic [IB-1:0]    set_idx,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             clr
);

  logic [XLEN-1:0]  data_q [LINES][WORDS];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  assign rd_valid_c = valid_q[rd_idx];
  assign rd_tag_c   = tag_q[rd_idx];
  assign rd_word_c  = data_q[rd_idx][rd_wsel];

  // Payload storage needs no reset: nothing is trusted until its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_idx][wr_wsel] <= wr_data;
    if (set_en) tag_q[set_idx] <= set_tag;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
    end else if (set_en) begin
      valid_q[set_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu5_icache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, in-order full-line
// refill on a miss, and a flush that invalidates all lines (deferred while refilling).
`ifndef CPU5_XLEN
`define CPU5_XLEN 32
`endif

module cpu5_icache
  import cpu5_icache_pkg::*;
#(
  parameter int unsigned XLEN   = `CPU5_XLEN,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINES  = 16,
  parameter int unsigned WORDS  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic [XLEN-1:0]   cpu_rdata,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned OFF = off_w(XLEN);
  localparam int unsigned WB  = wb_w(WORDS);
  localparam int unsigned IB  = ib_w(LINES);
  localparam int unsigned TW  = tag_w(ADDR_W, XLEN, LINES, WORDS);
  localparam logic [WB-1:0]     LAST_BEAT = WB'(WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << (OFF + WB);

  state_t            state_q, state_n;
  logic [WB-1:0]     beat_q, beat_n, beat_inc;
  logic              flush_pend_q, flush_pend_n;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_n;
  logic              cpu_valid_n, mem_req_n;
  logic [XLEN-1:0]   cpu_rdata_n;
  logic [ADDR_W-1:0] mem_addr_n, next_beat_addr;

  logic [TW-1:0]   cpu_tag, lat_tag, rd_tag_c;
  logic [IB-1:0]   cpu_idx, lat_idx, rd_idx;
  logic [WB-1:0]   cpu_wsel, lat_wsel, rd_wsel;
  logic            rd_valid_c, hit_c;
  logic [XLEN-1:0] rd_word_c;
  logic            wr_en, set_en, clr;

  assign cpu_tag  = cpu_addr[ADDR_W-1 -: TW];
  assign cpu_idx  = cpu_addr[OFF+WB +: IB];
  assign cpu_wsel = cpu_addr[OFF +: WB];
  assign lat_tag  = lat_addr_q[ADDR_W-1 -: TW];
  assign lat_idx  = lat_addr_q[OFF+WB +: IB];
  assign lat_wsel = lat_addr_q[OFF +: WB];

  // Lookup follows the incoming request in IDLE, the latched request otherwise.
  assign rd_idx  = (state_q == IDLE) ? cpu_idx  : lat_idx;
  assign rd_wsel = (state_q == IDLE) ? cpu_wsel : lat_wsel;
  assign hit_c   = rd_valid_c && (rd_tag_c == cpu_tag);

  assign beat_inc       = beat_q + WB'(1);
  assign next_beat_addr = (lat_addr_q & LINE_MASK) | (ADDR_W'(beat_inc) << OFF);

  cpu5_icache_array #(
    .XLEN  (XLEN),
    .LINES (LINES),
    .WORDS (WORDS),
    .TAG_W (TW)
  ) u_array (
    .clk        (clk),
    .resetn     (resetn),
    .rd_idx     (rd_idx),
    .rd_wsel    (rd_wsel),
    .rd_valid_c (rd_valid_c),
    .rd_tag_c   (rd_tag_c),
    .rd_word_c  (rd_word_c),
    .wr_en      (wr_en),
    .wr_idx     (lat_idx),
    .wr_wsel    (beat_q),
    .wr_data    (mem_rdata),
    .set_en     (set_en),
    .set_idx    (lat_idx),
    .set_tag    (lat_tag),
    .clr        (clr)
  );

  always_comb begin
    state_n      = state_q;
    beat_n       = beat_q;
    flush_pend_n = flush_pend_q;
    lat_addr_n   = lat_addr_q;
    cpu_valid_n  = 1'b0;
    cpu_rdata_n  = cpu_rdata;
    mem_req_n    = mem_req;
    mem_addr_n   = mem_addr;
    cpu_ready    = 1'b0;
    wr_en        = 1'b0;
    set_en       = 1'b0;
    clr          = 1'b0;

    case (state_q)
      IDLE: begin
        cpu_ready = !flush && !flush_pend_q;
        // A live or deferred flush takes the cycle; any request waits.
        if (flush || flush_pend_q) begin
          clr          = 1'b1;
          flush_pend_n = 1'b0;
        end else if (cpu_req) begin
          lat_addr_n = cpu_addr;
          if (hit_c) begin
            cpu_valid_n = 1'b1;
            cpu_rdata_n = rd_word_c;
          end else begin
            state_n    = REFILL;
            beat_n     = '0;
            mem_req_n  = 1'b1;
            mem_addr_n = cpu_addr & LINE_MASK;
          end
        end
      end

      REFILL: begin
        if (flush) flush_pend_n = 1'b1;
        if (mem_ack) begin
          wr_en  = 1'b1;
          beat_n = beat_inc;
          if (beat_q == LAST_BEAT) begin
            set_en    = 1'b1;
            mem_req_n = 1'b0;
            state_n   = RESP;
          end else begin
            mem_addr_n = next_beat_addr;
          end
        end
      end

      RESP: begin
        if (flush) flush_pend_n = 1'b1;
        cpu_valid_n = 1'b1;
        cpu_rdata_n = rd_word_c;
        state_n     = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      lat_addr_q   <= '0;
      cpu_valid    <= 1'b0;
      cpu_rdata    <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
    end else begin
      state_q      <= state_n;
      beat_q       <= beat_n;
      flush_pend_q <= flush_pend_n;
      lat_addr_q   <= lat_addr_n;
      cpu_valid    <= cpu_valid_n;
      cpu_rdata    <= cpu_rdata_n;
      mem_req      <= mem_req_n;
      mem_addr     <= mem_addr_n;
    end
  end

endmodule
